// File: rtl/mem_pkg.sv
// Shared geometry, address layout and rw encoding for the main-memory bank model.
// Constants only; no logic and no timing.
package mem_pkg;

  localparam int BANK_ADDR_W = 9;
  localparam int BANK_DATA_W = 128;
  localparam int BANK_SLICES = BANK_DATA_W / 8;
  localparam int SRAM_DEPTH  = (1 << BANK_ADDR_W) / 4;
  localparam int SRAM_ADDR_W = $clog2(SRAM_DEPTH);

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Upper bits pick the SRAM quarter and the rest index inside it.
  typedef struct packed {
    logic [1:0]             quarter;
    logic [SRAM_ADDR_W-1:0] index;
  } bank_addr_t;

endpackage

// File: rtl/bank_slice_dram.sv
// One byte lane of the bank, 512x8, built from four 128x8 quarters selected by the top address bits.
// Writes commit at the edge; q is combinational and is forced to zero when re is low.
module bank_slice_dram
  import mem_pkg::*;
#(
  parameter int SRAM_DEPTH = mem_pkg::SRAM_DEPTH
) (
  input  logic                   clk,
  input  logic [BANK_ADDR_W-1:0] addr,
  input  logic                   we,
  input  logic                   re,
  input  logic [7:0]             d,
  output logic [7:0]             q
);

  bank_addr_t w_a;
  logic [3:0] w_we;
  logic [7:0] w_q [4];

  assign w_a = addr;

  // Only the addressed quarter sees the write strobe, so a bad strobe cannot touch the other quarters.
  always_comb begin
    w_we = '0;
    w_we[w_a.quarter] = we;
  end

  sram_128x8 #(.DEPTH(SRAM_DEPTH)) sram0 (.clk(clk), .we(w_we[0]), .addr(w_a.index), .d(d), .q(w_q[0]));
  sram_128x8 #(.DEPTH(SRAM_DEPTH)) sram1 (.clk(clk), .we(w_we[1]), .addr(w_a.index), .d(d), .q(w_q[1]));
  sram_128x8 #(.DEPTH(SRAM_DEPTH)) sram2 (.clk(clk), .we(w_we[2]), .addr(w_a.index), .d(d), .q(w_q[2]));
  sram_128x8 #(.DEPTH(SRAM_DEPTH)) sram3 (.clk(clk), .we(w_we[3]), .addr(w_a.index), .d(d), .q(w_q[3]));

  assign q = re ? w_q[w_a.quarter] : 8'h00;

endmodule

// File: rtl/sram_128x8.sv
// Leaf 128x8 array: write lands at the rising edge, and the read is combinational.
// No reset on contents, so data preloaded into mem survives a bank reset.
module sram_128x8 #(
  parameter int DEPTH = mem_pkg::SRAM_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [7:0]               d,
  output logic [7:0]               q
);

  logic [7:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= d;
  end

  assign q = mem[addr];

endmodule

// File: rtl/bank.sv
// 512x128 single-port bank built from 16 byte-lane slices; a read returns data one cycle after addr is sampled.
// Every cycle may be a new access, the port never stalls, and dout holds except on a read or a reset.
module bank
  import mem_pkg::*;
#(
  parameter int ADDR_W     = BANK_ADDR_W,
  parameter int DATA_W     = BANK_DATA_W,
  parameter int NUM_SLICES = BANK_SLICES,
  parameter int SRAM_DEPTH = mem_pkg::SRAM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rw,
  input  logic              bnk_en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic              w_we;
  logic              w_re;
  logic [DATA_W-1:0] w_q;
  logic [DATA_W-1:0] r_dout;

  // Reset wins over a write in the same cycle.
  assign w_we = rst && bnk_en && (rw == RW_WRITE);
  assign w_re = bnk_en && (rw == RW_READ);

  for (genvar i = 0; i < NUM_SLICES; i++) begin : bank_slices
    bank_slice_dram #(.SRAM_DEPTH(SRAM_DEPTH)) dram (
      .clk  (clk),
      .addr (addr),
      .we   (w_we),
      .re   (w_re),
      .d    (din[8*i +: 8]),
      .q    (w_q[8*i +: 8])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst)      r_dout <= '0;
    else if (w_re) r_dout <= w_q;
  end

  assign dout = r_dout;

endmodule

// File: tb/tb_bank.sv
// Scoreboard bench for bank: stimulus updates a plain array model and queues the expected dout.
// A monitor compares that expectation against the DUT one step after every rising edge.
module tb_bank;
  import mem_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [8:0]   addr = '0;
  logic         rw = 1'b1;
  logic         bnk_en = 1'b0;
  logic [127:0] din = '0;
  logic [127:0] dout;

  bank dut (.clk(clk), .rst(rst), .addr(addr), .rw(rw), .bnk_en(bnk_en), .din(din), .dout(dout));

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] val;
    logic [8:0]   a;
    int           phase;
  } exp_t;

  exp_t         exp_q[$];
  logic [127:0] model [512];
  logic [127:0] exp_dout;
  int           phase = 0;
  int           checks = 0;
  int           errors = 0;
  bit           done = 0;

  // Slice g holds byte value g at every address in all four quarters.
  for (genvar g = 0; g < 16; g++) begin : pl
    initial begin
      for (int a = 0; a < 128; a++) begin
        dut.bank_slices[g].dram.sram0.mem[a] = 8'(g);
        dut.bank_slices[g].dram.sram1.mem[a] = 8'(g);
        dut.bank_slices[g].dram.sram2.mem[a] = 8'(g);
        dut.bank_slices[g].dram.sram3.mem[a] = 8'(g);
      end
    end
  end

  // Memory is an array of whole entries; dout changes only on reset or on a read.
  task automatic op(input logic r, input logic e, input logic w, input logic [8:0] a, input logic [127:0] d);
    @(negedge clk);
    rst = r; bnk_en = e; rw = w; addr = a; din = d;
    if (!r)               exp_dout = '0;
    else if (e && w)      exp_dout = model[a];
    else if (e && !w)     model[a] = d;
    exp_q.push_back('{exp_dout, a, phase});
  endtask

  task automatic rd(input logic [8:0] a);
    op(1'b1, 1'b1, RW_READ, a, $urandom);
  endtask

  task automatic wr(input logic [8:0] a, input logic [127:0] d);
    op(1'b1, 1'b1, RW_WRITE, a, d);
  endtask

  task automatic idle();
    op(1'b1, 1'b0, RW_READ, $urandom, {4{$urandom}});
  endtask

  task automatic sweep();
    for (int a = 0; a < 512; a++) rd(9'(a));
  endtask

  initial begin : monitor
    exp_t s;
    while (!done) begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        s = exp_q.pop_front();
        checks++;
        if (dout !== s.val) begin
          errors++;
          $display("FAIL dout phase%0d addr=%h got=%h exp=%h", s.phase, s.a, dout, s.val);
        end
      end
    end
  end

  initial begin : stim
    logic [127:0] pat;
    logic [127:0] v;
    logic [8:0]   hot [8];
    for (int i = 0; i < 16; i++) pat[8*i +: 8] = 8'(i);
    for (int a = 0; a < 512; a++) model[a] = pat;
    exp_dout = 'x;

    phase = 1;
    op(1'b0, 1'b0, RW_READ, '0, '0);
    op(1'b0, 1'b1, RW_READ, 9'h005, '0);
    sweep();

    phase = 2;
    for (int a = 0; a < 512; a++) begin
      wr(9'(a), {128{1'b1}});
      idle();
    end
    sweep();

    phase = 3;
    wr(9'h07F, 128'h00112233445566778899aabbccddeeff);
    wr(9'h080, {4{32'hdeadbeef}});
    rd(9'h07F);
    rd(9'h080);
    rd(9'h07E);
    rd(9'h081);

    phase = 4;
    for (int k = 0; k < 10; k++) op(1'b1, 1'b0, RW_WRITE, 9'($urandom), {64{2'b01}});
    sweep();

    phase = 5;
    rd(9'h030);
    op(1'b0, 1'b1, RW_WRITE, 9'h010, 128'h1234);
    rd(9'h010);
    rd(9'h07F);
    rd(9'h080);
    rd(9'h000);

    phase = 6;
    wr(9'h1FF, {16{8'hA5}});
    rd(9'h1FF);
    rd(9'h000);
    wr(9'h000, 128'h0);
    rd(9'h1FF);
    rd(9'h000);

    phase = 7;
    for (int k = 0; k < 8; k++) hot[k] = 9'($urandom);
    hot[0] = 9'h07F; hot[1] = 9'h080; hot[2] = 9'h1FF; hot[3] = 9'h000;
    for (int k = 0; k < 3000; k++) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      op(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0), 1'($urandom),
         ($urandom_range(0, 1) != 0) ? hot[$urandom_range(0, 7)] : 9'($urandom), v);
    end
    sweep();

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end
    done = 1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
